// File: rtl/prio_sched.sv
// Strict-priority, packet-atomic scheduler: grants the lowest-index queue holding a
// complete packet and forwards it word by word through a one-word output register.
module prio_sched #(
  parameter int NUM_PRIO   = 8,
  parameter int DATA_WIDTH = 16,
  parameter int PRIO_W     = 3
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_PRIO-1:0]            q_ready_i,
  input  logic [NUM_PRIO-1:0]            q_sop_i,
  input  logic [NUM_PRIO-1:0]            q_eop_i,
  input  logic [NUM_PRIO-1:0]            q_vld_i,
  input  logic [NUM_PRIO*DATA_WIDTH-1:0] q_data_i,
  output logic [NUM_PRIO-1:0]            q_next_o,
  output logic                           out_sop_o,
  output logic                           out_eop_o,
  output logic                           out_vld_o,
  output logic [DATA_WIDTH-1:0]          out_data_o,
  input  logic                           out_ready_i,
  output logic [PRIO_W-1:0]              grant_id_o,
  output logic                           busy_o,
  output logic                           pkt_err_o
);

  // state | meaning
  // IDLE  | arbitrate among queues with a complete packet
  // XFER  | waiting to load the granted queue's head word
  // GAP   | one cycle for the FIFO to present its next head word
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_XFER = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [PRIO_W-1:0]     grant_q, grant_d;
  logic                  busy_q, busy_d;
  logic                  first_q, first_d;
  logic [NUM_PRIO-1:0]   q_next_q, q_next_d;
  logic                  pkt_err_q, pkt_err_d;
  logic                  out_vld_q, out_vld_d;
  logic                  out_sop_q, out_sop_d;
  logic                  out_eop_q, out_eop_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

  logic [PRIO_W-1:0]     pick_idx;
  logic                  pick_any;
  logic                  hd_vld, hd_sop, hd_eop;
  logic [DATA_WIDTH-1:0] hd_data;
  logic                  slot_free, load;

  always_comb begin
    pick_idx = '0;
    pick_any = |q_ready_i;
    // Descending scan so the lowest set index wins.
    for (int i = NUM_PRIO - 1; i >= 0; i--) begin
      if (q_ready_i[i]) pick_idx = PRIO_W'(i);
    end
  end

  always_comb begin
    hd_vld    = q_vld_i[grant_q];
    hd_sop    = q_sop_i[grant_q];
    hd_eop    = q_eop_i[grant_q];
    hd_data   = q_data_i[grant_q*DATA_WIDTH +: DATA_WIDTH];
    slot_free = !out_vld_q || out_ready_i;
    load      = (state_q == ST_XFER) && hd_vld && slot_free;
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    busy_d     = busy_q;
    first_d    = first_q;
    q_next_d   = '0;
    pkt_err_d  = 1'b0;
    out_vld_d  = out_vld_q;
    out_sop_d  = out_sop_q;
    out_eop_d  = out_eop_q;
    out_data_d = out_data_q;

    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          busy_d  = 1'b1;
          first_d = 1'b1;
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        if (load) begin
          q_next_d  = NUM_PRIO'(1) << grant_q;
          pkt_err_d = first_q ? !hd_sop : hd_sop;
          first_d   = 1'b0;
          if (hd_eop) begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_GAP;
          end
        end
      end
      ST_GAP:  state_d = ST_XFER;
      default: state_d = ST_IDLE;
    endcase

    // Load and accept in the same cycle replace the word without a bubble.
    if (load) begin
      out_vld_d  = 1'b1;
      out_sop_d  = hd_sop;
      out_eop_d  = hd_eop;
      out_data_d = hd_data;
    end else if (out_ready_i) begin
      out_vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      busy_q     <= 1'b0;
      first_q    <= 1'b0;
      q_next_q   <= '0;
      pkt_err_q  <= 1'b0;
      out_vld_q  <= 1'b0;
      out_sop_q  <= 1'b0;
      out_eop_q  <= 1'b0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      busy_q     <= busy_d;
      first_q    <= first_d;
      q_next_q   <= q_next_d;
      pkt_err_q  <= pkt_err_d;
      out_vld_q  <= out_vld_d;
      out_sop_q  <= out_sop_d;
      out_eop_q  <= out_eop_d;
      out_data_q <= out_data_d;
    end
  end

  assign q_next_o   = q_next_q;
  assign out_sop_o  = out_sop_q;
  assign out_eop_o  = out_eop_q;
  assign out_vld_o  = out_vld_q;
  assign out_data_o = out_data_q;
  assign grant_id_o = grant_q;
  assign busy_o     = busy_q;
  assign pkt_err_o  = pkt_err_q;

endmodule

// File: tb/tb_prio_sched.sv
// Directed bench for prio_sched: a small per-queue FIFO model feeds the head words,
// and each step compares the registered outputs against hand-derived values.
module tb_prio_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  q_ready = '0;
  logic [7:0]  q_sop = '0;
  logic [7:0]  q_eop = '0;
  logic [7:0]  q_vld = '0;
  logic [127:0] q_data = '0;
  logic [7:0]  q_next;
  logic        out_sop, out_eop, out_vld;
  logic [15:0] out_data;
  logic        out_ready = 1'b1;
  logic [2:0]  grant_id;
  logic        busy, pkt_err;

  int checks = 0;
  int errors = 0;

  // FIFO word layout: [17] sop, [16] eop, [15:0] data
  logic [17:0] mem [8][8];
  int          rd_ptr [8];
  int          wr_ptr [8];

  prio_sched #(.NUM_PRIO(8), .DATA_WIDTH(16), .PRIO_W(3)) dut (
    .clk_i(clk), .rst_i(rst),
    .q_ready_i(q_ready), .q_sop_i(q_sop), .q_eop_i(q_eop), .q_vld_i(q_vld),
    .q_data_i(q_data), .q_next_o(q_next),
    .out_sop_o(out_sop), .out_eop_o(out_eop), .out_vld_o(out_vld),
    .out_data_o(out_data), .out_ready_i(out_ready),
    .grant_id_o(grant_id), .busy_o(busy), .pkt_err_o(pkt_err)
  );

  always #5 clk = ~clk;

  task automatic refresh();
    for (int i = 0; i < 8; i++) begin
      logic [17:0] w;
      logic        rdy;
      w = '0;
      rdy = 1'b0;
      if (rd_ptr[i] < wr_ptr[i]) w = mem[i][rd_ptr[i]];
      for (int j = rd_ptr[i]; j < wr_ptr[i]; j++) begin
        logic [17:0] e;
        e = mem[i][j];
        if (e[16]) rdy = 1'b1;
      end
      q_vld[i]            = (rd_ptr[i] < wr_ptr[i]);
      q_sop[i]            = w[17];
      q_eop[i]            = w[16];
      q_data[i*16 +: 16]  = w[15:0];
      q_ready[i]          = rdy;
    end
  endtask

  task automatic push(input int q, input logic sop, input logic eop, input logic [15:0] d);
    mem[q][wr_ptr[q]] = {sop, eop, d};
    wr_ptr[q] = wr_ptr[q] + 1;
    refresh();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      if (q_next[i] && rd_ptr[i] < wr_ptr[i]) rd_ptr[i] = rd_ptr[i] + 1;
    end
    refresh();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_q_next"},  32'(q_next), 32'h0);
    chk({tag, "_out_vld"}, 32'(out_vld), 32'h0);
    chk({tag, "_out_sop"}, 32'(out_sop), 32'h0);
    chk({tag, "_out_eop"}, 32'(out_eop), 32'h0);
    chk({tag, "_data"},    32'(out_data), 32'h0);
    chk({tag, "_grant"},   32'(grant_id), 32'h0);
    chk({tag, "_busy"},    32'(busy), 32'h0);
    chk({tag, "_pkt_err"}, 32'(pkt_err), 32'h0);
  endtask

  task automatic expect_grant(input string tag, input int q);
    tick();
    chk({tag, "_busy"},   32'(busy), 32'h1);
    chk({tag, "_grant"},  32'(grant_id), 32'(q));
    chk({tag, "_q_next"}, 32'(q_next), 32'h0);
  endtask

  task automatic expect_load(input string tag, input int q, input logic [15:0] d,
                             input logic sop, input logic eop, input logic err);
    tick();
    chk({tag, "_q_next"},  32'(q_next), 32'h1 << q);
    chk({tag, "_out_vld"}, 32'(out_vld), 32'h1);
    chk({tag, "_data"},    32'(out_data), 32'(d));
    chk({tag, "_sop"},     32'(out_sop), 32'(sop));
    chk({tag, "_eop"},     32'(out_eop), 32'(eop));
    chk({tag, "_pkt_err"}, 32'(pkt_err), 32'(err));
    chk({tag, "_busy"},    32'(busy), 32'(!eop));
  endtask

  task automatic expect_gap(input string tag);
    tick();
    chk({tag, "_q_next"},  32'(q_next), 32'h0);
    chk({tag, "_pkt_err"}, 32'(pkt_err), 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      rd_ptr[i] = 0;
      wr_ptr[i] = 0;
    end
    refresh();

    tick();
    tick();
    chk_zero("reset");
    rst = 1'b0;
    tick();
    chk("idle_busy", 32'(busy), 32'h0);

    // single 4-word packet on queue 3
    push(3, 1'b1, 1'b0, 16'hA000);
    push(3, 1'b0, 1'b0, 16'hA001);
    push(3, 1'b0, 1'b0, 16'hA002);
    push(3, 1'b0, 1'b1, 16'hA003);
    expect_grant("a_grant", 3);
    chk("a_vld_before", 32'(out_vld), 32'h0);
    expect_load("a0", 3, 16'hA000, 1'b1, 1'b0, 1'b0);
    expect_gap("a0_gap");
    chk("a0_gap_vld", 32'(out_vld), 32'h0);
    expect_load("a1", 3, 16'hA001, 1'b0, 1'b0, 1'b0);
    expect_gap("a1_gap");
    expect_load("a2", 3, 16'hA002, 1'b0, 1'b0, 1'b0);
    expect_gap("a2_gap");
    expect_load("a3", 3, 16'hA003, 1'b0, 1'b1, 1'b0);
    tick();
    chk("a_idle_busy", 32'(busy), 32'h0);
    chk("a_idle_vld", 32'(out_vld), 32'h0);

    // strict priority: queue 1 beats queue 5
    push(5, 1'b1, 1'b0, 16'hB000);
    push(5, 1'b0, 1'b1, 16'hB001);
    push(1, 1'b1, 1'b0, 16'hC000);
    push(1, 1'b0, 1'b1, 16'hC001);
    expect_grant("p_grant1", 1);
    expect_load("c0", 1, 16'hC000, 1'b1, 1'b0, 1'b0);
    expect_gap("c0_gap");
    expect_load("c1", 1, 16'hC001, 1'b0, 1'b1, 1'b0);
    expect_grant("p_grant5", 5);
    expect_load("b0", 5, 16'hB000, 1'b1, 1'b0, 1'b0);
    expect_gap("b0_gap");
    expect_load("b1", 5, 16'hB001, 1'b0, 1'b1, 1'b0);
    tick();

    // atomicity: queue 0 becomes ready during word 2 of a queue-4 packet
    push(4, 1'b1, 1'b0, 16'hD000);
    push(4, 1'b0, 1'b0, 16'hD001);
    push(4, 1'b0, 1'b1, 16'hD002);
    expect_grant("t_grant4", 4);
    expect_load("d0", 4, 16'hD000, 1'b1, 1'b0, 1'b0);
    expect_gap("d0_gap");
    expect_load("d1", 4, 16'hD001, 1'b0, 1'b0, 1'b0);
    push(0, 1'b1, 1'b0, 16'hE000);
    push(0, 1'b0, 1'b1, 16'hE001);
    expect_gap("d1_gap");
    chk("t_grant_hold", 32'(grant_id), 32'h4);
    expect_load("d2", 4, 16'hD002, 1'b0, 1'b1, 1'b0);
    expect_grant("t_grant0", 0);
    expect_load("e0", 0, 16'hE000, 1'b1, 1'b0, 1'b0);
    expect_gap("e0_gap");
    expect_load("e1", 0, 16'hE001, 1'b0, 1'b1, 1'b0);
    tick();

    // backpressure on queue 6
    push(6, 1'b1, 1'b0, 16'hF000);
    push(6, 1'b0, 1'b1, 16'hF001);
    expect_grant("bp_grant", 6);
    expect_load("f0", 6, 16'hF000, 1'b1, 1'b0, 1'b0);
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_q_next", 32'(q_next), 32'h0);
      chk("bp_vld", 32'(out_vld), 32'h1);
      chk("bp_data", 32'(out_data), 32'hF000);
    end
    out_ready = 1'b1;
    expect_load("f1", 6, 16'hF001, 1'b0, 1'b1, 1'b0);
    tick();

    // framing errors on queue 7
    push(7, 1'b0, 1'b0, 16'h7000);
    push(7, 1'b1, 1'b0, 16'h7001);
    push(7, 1'b0, 1'b1, 16'h7002);
    expect_grant("fr_grant", 7);
    expect_load("g0", 7, 16'h7000, 1'b0, 1'b0, 1'b1);
    expect_gap("g0_gap");
    expect_load("g1", 7, 16'h7001, 1'b1, 1'b0, 1'b1);
    expect_gap("g1_gap");
    expect_load("g2", 7, 16'h7002, 1'b0, 1'b1, 1'b0);
    tick();

    // reset during GAP of a queue-2 transfer
    push(2, 1'b1, 1'b0, 16'h2000);
    push(2, 1'b0, 1'b0, 16'h2001);
    push(2, 1'b0, 1'b1, 16'h2002);
    expect_grant("r_grant", 2);
    expect_load("h0", 2, 16'h2000, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    chk_zero("midrst");
    rst = 1'b0;
    expect_grant("r_regrant", 2);
    expect_load("h1", 2, 16'h2001, 1'b0, 1'b0, 1'b1);
    expect_gap("h1_gap");
    expect_load("h2", 2, 16'h2002, 1'b0, 1'b1, 1'b0);
    tick();
    chk("end_busy", 32'(busy), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
